// File: rtl/iot_fleet_monitor.sv
// iot_fleet_monitor: N_CH up/down device counters with sticky flags,
// a registered fleet total and a hysteresis alarm on that total.
module iot_fleet_monitor #(
    parameter int WIDTH    = 8,
    parameter int N_CH     = 4,
    parameter bit SATURATE = 1'b0,
    parameter int TW       = (N_CH > 1) ? WIDTH + $clog2(N_CH) : WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         change,
    input  logic [N_CH-1:0]         on_off,
    input  logic                    clr,
    input  logic                    flag_clr,
    input  logic [TW-1:0]           hi_thr,
    input  logic [TW-1:0]           lo_thr,
    output logic [N_CH*WIDTH-1:0]   counter_out,
    output logic [N_CH-1:0]         ovf,
    output logic [N_CH-1:0]         unf,
    output logic [TW-1:0]           total,
    output logic                    alarm
);

    localparam logic [WIDTH-1:0] CMAX = '1;
    localparam logic [WIDTH-1:0] CMIN = '0;

    logic [WIDTH-1:0] cnt     [N_CH];
    logic [WIDTH-1:0] cnt_nxt [N_CH];
    logic [N_CH-1:0]  inc_hit;
    logic [N_CH-1:0]  dec_hit;
    logic [TW-1:0]    sum;
    logic             set_hit;
    logic             rel_hit;

    // A clr cycle suppresses both the count update and any flag set.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            inc_hit[i] = 1'b0;
            dec_hit[i] = 1'b0;
            if (clr) begin
                cnt_nxt[i] = '0;
            end else if (!change[i]) begin
                cnt_nxt[i] = cnt[i];
            end else if (on_off[i]) begin
                inc_hit[i] = (cnt[i] == CMAX);
                if (inc_hit[i] && SATURATE)
                    cnt_nxt[i] = CMAX;
                else
                    cnt_nxt[i] = cnt[i] + WIDTH'(1);
            end else begin
                dec_hit[i] = (cnt[i] == CMIN);
                if (dec_hit[i] && SATURATE)
                    cnt_nxt[i] = CMIN;
                else
                    cnt_nxt[i] = cnt[i] - WIDTH'(1);
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CH; i++)
            sum = sum + TW'(cnt[i]);
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++)
            counter_out[i*WIDTH +: WIDTH] = cnt[i];
    end

    assign set_hit = (total >= hi_thr);
    assign rel_hit = (total <= lo_thr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= '0;
            ovf   <= '0;
            unf   <= '0;
            total <= '0;
            alarm <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                cnt[i] <= cnt_nxt[i];
            // A new set in the same cycle as flag_clr survives.
            ovf   <= (flag_clr ? '0 : ovf) | inc_hit;
            unf   <= (flag_clr ? '0 : unf) | dec_hit;
            total <= clr ? '0 : sum;
            if (clr)
                alarm <= 1'b0;
            else if (set_hit)
                alarm <= 1'b1;
            else if (rel_hit)
                alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iot_fleet_monitor.sv
// Bench for iot_fleet_monitor: wrap and saturate instances side by side,
// checked each cycle against an integer model plus directed literals.
module tb_iot_fleet_monitor;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TW = W + $clog2(N);
    localparam int MX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] change, on_off;
    logic clr, flag_clr;
    logic [TW-1:0] hi_thr, lo_thr;

    logic [N*W-1:0] co [2];
    logic [N-1:0]   ov [2];
    logic [N-1:0]   un [2];
    logic [TW-1:0]  tt [2];
    logic           al [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iot_fleet_monitor #(.WIDTH(W), .N_CH(N), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off),
        .clr(clr), .flag_clr(flag_clr), .hi_thr(hi_thr), .lo_thr(lo_thr),
        .counter_out(co[0]), .ovf(ov[0]), .unf(un[0]),
        .total(tt[0]), .alarm(al[0])
    );

    iot_fleet_monitor #(.WIDTH(W), .N_CH(N), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off),
        .clr(clr), .flag_clr(flag_clr), .hi_thr(hi_thr), .lo_thr(lo_thr),
        .counter_out(co[1]), .ovf(ov[1]), .unf(un[1]),
        .total(tt[1]), .alarm(al[1])
    );

    // Model: m=0 wrap, m=1 saturate.
    int m_cnt [2][N];
    bit m_ovf [2][N];
    bit m_unf [2][N];
    int m_tot [2];
    bit m_alm [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) begin
                    m_cnt[m][i] = 0;
                    m_ovf[m][i] = 0;
                    m_unf[m][i] = 0;
                end
                m_tot[m] = 0;
                m_alm[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int s;
                if (clr) m_alm[m] = 0;
                else if (m_tot[m] >= int'(hi_thr)) m_alm[m] = 1;
                else if (m_tot[m] <= int'(lo_thr)) m_alm[m] = 0;
                s = 0;
                for (int i = 0; i < N; i++) s += m_cnt[m][i];
                m_tot[m] = clr ? 0 : s;
                for (int i = 0; i < N; i++) begin
                    if (flag_clr) begin
                        m_ovf[m][i] = 0;
                        m_unf[m][i] = 0;
                    end
                    if (clr) begin
                        m_cnt[m][i] = 0;
                    end else if (change[i] && on_off[i]) begin
                        if (m_cnt[m][i] == MX) begin
                            m_ovf[m][i] = 1;
                            m_cnt[m][i] = (m == 1) ? MX : 0;
                        end else begin
                            m_cnt[m][i] += 1;
                        end
                    end else if (change[i]) begin
                        if (m_cnt[m][i] == 0) begin
                            m_unf[m][i] = 1;
                            m_cnt[m][i] = (m == 1) ? 0 : MX;
                        end else begin
                            m_cnt[m][i] -= 1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic [N*W-1:0] ec;
            logic [N-1:0] eo, eu;
            for (int i = 0; i < N; i++) begin
                ec[i*W +: W] = W'(m_cnt[m][i]);
                eo[i] = m_ovf[m][i];
                eu[i] = m_unf[m][i];
            end
            chk($sformatf("cyc_cnt%0d", m), 64'(co[m]), 64'(ec));
            chk($sformatf("cyc_ovf%0d", m), 64'(ov[m]), 64'(eo));
            chk($sformatf("cyc_unf%0d", m), 64'(un[m]), 64'(eu));
            chk($sformatf("cyc_tot%0d", m), 64'(tt[m]), 64'(m_tot[m]));
            chk($sformatf("cyc_alm%0d", m), 64'(al[m]), 64'(m_alm[m]));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] c, input logic [N-1:0] o);
        change = c;
        on_off = o;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b0000, 4'b0000);
        clr = 1'b0;
        flag_clr = 1'b0;
        hi_thr = 10'd1023;
        lo_thr = 10'd0;
        tick(2);
        rst = 1'b0;
        chk("rst_cnt", 64'(co[0]), 64'd0);
        chk("rst_tot", 64'(tt[1]), 64'd0);

        // Wrap / saturate at zero
        drive(4'b0001, 4'b0000);
        tick();
        chk("wrap_dn", 64'(co[0][7:0]), 64'd255);
        chk("wrap_unf", 64'(un[0][0]), 64'd1);
        chk("sat_dn", 64'(co[1][7:0]), 64'd0);
        drive(4'b0001, 4'b0001);
        tick();
        chk("wrap_up", 64'(co[0][7:0]), 64'd0);
        chk("unf_sticky", 64'(un[0][0]), 64'd1);
        drive(4'b0000, 4'b0000);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("unf_clr", 64'(un[0][0]), 64'd0);

        // Saturate at max; flag_clr loses to a same-cycle set
        drive(4'b0010, 4'b0010);
        tick(260);
        chk("sat_up", 64'(co[1][15:8]), 64'd255);
        chk("sat_ovf", 64'(ov[1][1]), 64'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("sat_ovf_win", 64'(ov[1][1]), 64'd1);
        chk("wrap_ch1", 64'(co[0][15:8]), 64'd5);
        chk("wrap_ovf_clr", 64'(ov[0][1]), 64'd0);

        // Asynchronous reset mid-cycle
        drive(4'b1111, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt", 64'(co[1]), 64'd0);
        chk("arst_ovf", 64'(ov[1]), 64'd0);
        tick();
        chk("arst_hold", 64'(co[0]), 64'd0);
        rst = 1'b0;

        // Independence and hold
        drive(4'b1011, 4'b1001);
        tick(10);
        chk("ind_wrap", 64'(co[0]), 64'h0A_00_F6_0A);
        chk("ind_sat", 64'(co[1]), 64'h0A_00_00_0A);
        drive(4'b0000, 4'b0000);
        tick(2);
        chk("ind_tot0", 64'(tt[0]), 64'd266);
        chk("ind_tot1", 64'(tt[1]), 64'd20);

        // Alarm hysteresis
        rst = 1'b1;
        hi_thr = 10'd20;
        lo_thr = 10'd10;
        tick();
        rst = 1'b0;
        drive(4'b0001, 4'b0001);
        tick(20);
        chk("alm_cnt20", 64'(co[0][7:0]), 64'd20);
        drive(4'b0000, 4'b0000);
        tick();
        chk("alm_lat1", 64'(al[0]), 64'd0);
        tick();
        chk("alm_set", 64'(al[0]), 64'd1);
        drive(4'b0001, 4'b0000);
        tick(9);
        chk("alm_cnt11", 64'(co[0][7:0]), 64'd11);
        drive(4'b0000, 4'b0000);
        tick(2);
        chk("alm_hold11", 64'(al[1]), 64'd1);
        drive(4'b0001, 4'b0000);
        tick();
        drive(4'b0000, 4'b0000);
        tick();
        chk("alm_lat10", 64'(al[0]), 64'd1);
        tick();
        chk("alm_rel", 64'(al[0]), 64'd0);

        // Clear: counters/total/alarm drop, flags stay
        drive(4'b1000, 4'b1000);
        tick(256);
        drive(4'b0000, 4'b0000);
        hi_thr = 10'd5;
        lo_thr = 10'd2;
        tick(3);
        chk("clr_pre_alm", 64'(al[0]), 64'd1);
        chk("clr_pre_ovf", 64'(ov[1]), 64'b1000);
        clr = 1'b1;
        drive(4'b1111, 4'b1111);
        tick();
        clr = 1'b0;
        drive(4'b0000, 4'b0000);
        chk("clr_cnt", 64'(co[1]), 64'd0);
        chk("clr_tot", 64'(tt[1]), 64'd0);
        chk("clr_alm", 64'(al[1]), 64'd0);
        chk("clr_ovf", 64'(ov[0]), 64'b1000);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
